// File: rtl/shreg_rr_arbiter.sv
// Round-robin arbiter and write sequencer for one shared register with q/qn outputs.
// Optional burst-lock mode is enabled with the SHREG_LOCK_EN macro (adds the lock port).
module shreg_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     wr_data,
`ifdef SHREG_LOCK_EN
  input  logic [N_REQ-1:0]           lock,
`endif
  output logic [N_REQ-1:0]           gnt,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           qn,
  output logic                       wr_done
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t             r_state;
  logic [N_REQ-1:0]   r_gnt;
  logic [PTR_W-1:0]   r_owner;
  logic [PTR_W-1:0]   r_ptr;
  logic [WIDTH-1:0]   r_q;
  logic               r_wr_done;

  state_t             w_state_nxt;
  logic [N_REQ-1:0]   w_gnt_nxt;
  logic [PTR_W-1:0]   w_owner_nxt;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [WIDTH-1:0]   w_q_nxt;
  logic               w_wr_done_nxt;
  logic [PTR_W-1:0]   w_winner;
  logic [WIDTH-1:0]   w_slice;
  logic               w_lock_own;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
    if (int'(v) == N_REQ - 1) return '0;
    else                      return v + PTR_W'(1);
  endfunction

  // First set request bit at or after start, wrapping modulo N_REQ.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [PTR_W-1:0] start);
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] pick;
    logic             found;
    idx   = start;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = wrap_inc(idx);
    end
    return pick;
  endfunction

  assign w_winner = rr_pick(req, r_ptr);
  assign w_slice  = wr_data[int'(r_owner)*WIDTH +: WIDTH];

`ifdef SHREG_LOCK_EN
  assign w_lock_own = lock[r_owner];
`else
  assign w_lock_own = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_owner_nxt   = r_owner;
    w_ptr_nxt     = r_ptr;
    w_q_nxt       = r_q;
    w_wr_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = N_REQ'(1) << w_winner;
          w_owner_nxt = w_winner;
          w_ptr_nxt   = wrap_inc(w_winner);
        end
      end
      S_GRANT: begin
        // Non-owner requests are ignored here; they compete again from IDLE.
        if (req[r_owner]) begin
          w_q_nxt       = w_slice;
          w_wr_done_nxt = 1'b1;
          if (!w_lock_own) begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
          end
        end else begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_q       <= '0;
      r_wr_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_owner   <= w_owner_nxt;
      r_ptr     <= w_ptr_nxt;
      r_q       <= w_q_nxt;
      r_wr_done <= w_wr_done_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign owner   = r_owner;
  assign q       = r_q;
  assign qn      = ~r_q;
  assign wr_done = r_wr_done;

endmodule
